// File: rtl/stopwatch_disp.sv
// -----------------------------------------------------------------------------
// stopwatch_disp
//   Four-digit BCD stopwatch (SS.hh, 00.00..99.99) with a multiplexed,
//   active-low seven-segment display. time_clk and slow_clk are square waves
//   from the clock divider in the clk domain; they are sampled and
//   edge-detected here, never used as clocks.
//
// Parameters
//   WRAP      1: a tick at 99.99 wraps to 00.00 and keeps running
//             0: a tick at 99.99 holds 99.99 and pauses
//   BLANK_LZ  1: blank the tens-of-seconds digit when it is zero
//
// Ports
//   clk         in  1  system clock, sole clock of the block
//   reset       in  1  asynchronous active-low reset
//   time_clk    in  1  count tick square wave, each rise = 1/100 s
//   slow_clk    in  1  scan square wave, each rise advances the digit index
//   start_stop  in  1  debounced level, rise toggles run/pause
//   clear       in  1  debounced level, rise zeroes the count and idles
//   an          out 4  anode enables, active-low, an[0] = rightmost digit
//   seg         out 7  cathodes {g,f,e,d,c,b,a}, active-low
//   dp          out 1  decimal point, active-low
//   running     out 1  high while counting
//   overflow    out 1  sticky, set by a tick at 99.99
// -----------------------------------------------------------------------------
module stopwatch_disp #(
   parameter bit WRAP     = 1'b1,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       time_clk,
   input  logic       slow_clk,
   input  logic       start_stop,
   input  logic       clear,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       running,
   output logic       overflow
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_d;          // {d3,d2,d1,d0}
   logic [15:0] w_d_nxt;
   logic        r_ovf;
   logic        w_ovf_nxt;
   logic [1:0]  r_idx;

   logic        r_tclk_prev;
   logic        r_sclk_prev;
   logic        r_ss_prev;
   logic        r_clr_prev;
   logic        w_tick;
   logic        w_scan;
   logic        w_ss;
   logic        w_clr;

   logic [3:0]  r_an;
   logic [6:0]  r_seg;
   logic        r_dp;
   logic [3:0]  w_an;
   logic [6:0]  w_seg;
   logic        w_dp;
   logic [3:0]  w_digit;

   function automatic logic [6:0] decode7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // Ripple the carry through all four digits combinationally so that
   // e.g. 09.99 -> 10.00 resolves on a single clk edge.
   function automatic logic [15:0] bcd_inc(input logic [15:0] d);
      logic [15:0] q;
      logic        c;
      q = d;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (d[i*4 +: 4] == 4'd9) begin
               q[i*4 +: 4] = 4'd0;
            end else begin
               q[i*4 +: 4] = d[i*4 +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return q;
   endfunction

   // Prev registers reset to 1 so a level already high at reset release
   // is not mistaken for a rising edge.
   assign w_tick = time_clk   & ~r_tclk_prev;
   assign w_scan = slow_clk   & ~r_sclk_prev;
   assign w_ss   = start_stop & ~r_ss_prev;
   assign w_clr  = clear      & ~r_clr_prev;

   // Clear dominates; otherwise the button decides the next state and the
   // tick is gated by the registered state, so a tick on the start edge is
   // ignored while a tick on the pause edge still counts.
   always_comb begin
      w_state_nxt = r_state;
      w_d_nxt     = r_d;
      w_ovf_nxt   = r_ovf;
      if (w_clr) begin
         w_state_nxt = IDLE;
         w_d_nxt     = '0;
         w_ovf_nxt   = 1'b0;
      end else begin
         if (w_ss) begin
            case (r_state)
               IDLE:    w_state_nxt = RUN;
               RUN:     w_state_nxt = PAUSE;
               PAUSE:   w_state_nxt = RUN;
               default: w_state_nxt = IDLE;
            endcase
         end
         if (w_tick && (r_state == RUN)) begin
            if (r_d == 16'h9999) begin
               w_ovf_nxt = 1'b1;
               if (WRAP) begin
                  w_d_nxt = '0;
               end else begin
                  w_state_nxt = PAUSE;
               end
            end else begin
               w_d_nxt = bcd_inc(r_d);
            end
         end
      end
   end

   always_comb begin
      case (r_idx)
         2'd0:    w_digit = r_d[3:0];
         2'd1:    w_digit = r_d[7:4];
         2'd2:    w_digit = r_d[11:8];
         default: w_digit = r_d[15:12];
      endcase
      w_an  = ~(4'b0001 << r_idx);
      w_seg = decode7(w_digit);
      w_dp  = (r_idx != 2'd2);
      if (BLANK_LZ && (r_idx == 2'd3) && (r_d[15:12] == 4'd0)) begin
         w_seg = 7'h7F;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tclk_prev <= 1'b1;
         r_sclk_prev <= 1'b1;
         r_ss_prev   <= 1'b1;
         r_clr_prev  <= 1'b1;
         r_state     <= IDLE;
         r_d         <= '0;
         r_ovf       <= 1'b0;
         r_idx       <= '0;
         r_an        <= 4'hF;
         r_seg       <= 7'h7F;
         r_dp        <= 1'b1;
      end else begin
         r_tclk_prev <= time_clk;
         r_sclk_prev <= slow_clk;
         r_ss_prev   <= start_stop;
         r_clr_prev  <= clear;
         r_state     <= w_state_nxt;
         r_d         <= w_d_nxt;
         r_ovf       <= w_ovf_nxt;
         if (w_scan) begin
            r_idx <= r_idx + 2'd1;
         end
         // display lags (idx, digits) by one cycle
         r_an        <= w_an;
         r_seg       <= w_seg;
         r_dp        <= w_dp;
      end
   end

   assign an       = r_an;
   assign seg      = r_seg;
   assign dp       = r_dp;
   assign running  = (r_state == RUN);
   assign overflow = r_ovf;

endmodule

// File: tb/tb_stopwatch_disp.sv
module tb_stopwatch_disp;

   logic       clk = 1'b0;
   logic       reset;
   logic       time_clk;
   logic       slow_clk;
   logic       start_stop;
   logic       clear;
   logic [3:0] an,  an_h;
   logic [6:0] seg, seg_h;
   logic       dp,  dp_h;
   logic       running,  running_h;
   logic       overflow, overflow_h;

   always #5 clk = ~clk;

   stopwatch_disp #(.WRAP(1'b1), .BLANK_LZ(1'b1)) dut (
      .clk(clk), .reset(reset), .time_clk(time_clk), .slow_clk(slow_clk),
      .start_stop(start_stop), .clear(clear),
      .an(an), .seg(seg), .dp(dp), .running(running), .overflow(overflow)
   );

   stopwatch_disp #(.WRAP(1'b0), .BLANK_LZ(1'b1)) dut_hold (
      .clk(clk), .reset(reset), .time_clk(time_clk), .slow_clk(slow_clk),
      .start_stop(start_stop), .clear(clear),
      .an(an_h), .seg(seg_h), .dp(dp_h), .running(running_h), .overflow(overflow_h)
   );

   typedef struct {
      string      name;
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } disp_t;

   disp_t sb_q[$];
   disp_t tbl[5];

   int         n_chk = 0;
   int         n_err = 0;
   int         m_cnt = 0;      // model count 0..9999 (WRAP=1 instance)
   bit         m_run = 1'b0;
   logic [1:0] m_idx = 2'd0;

   function automatic logic [6:0] enc(input int d);
      case (d)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic disp_t mk(input string nm, input logic [3:0] a,
                                input logic [6:0] s, input logic d);
      disp_t e;
      e.name = nm;
      e.an   = a;
      e.seg  = s;
      e.dp   = d;
      return e;
   endfunction

   function automatic disp_t exp_disp(input string nm, input int v, input logic [1:0] idx);
      disp_t      e;
      int         p;
      logic [3:0] one;
      one = 4'b0001;
      p = (idx == 2'd0) ? 1 : (idx == 2'd1) ? 10 : (idx == 2'd2) ? 100 : 1000;
      e.name = nm;
      e.an   = ~(one << idx);
      e.seg  = ((idx == 2'd3) && (v < 1000)) ? 7'h7F : enc((v / p) % 10);
      e.dp   = (idx != 2'd2);
      return e;
   endfunction

   function automatic logic [15:0] pk(input logic [3:0] a, input logic [6:0] s, input logic d);
      return {4'h0, a, s, d};
   endfunction

   function void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   function void chk1(input string nm, input logic act, input logic exp);
      chk(nm, {15'd0, act}, {15'd0, exp});
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tick();
      time_clk = 1'b1;
      cyc(1);
      time_clk = 1'b0;
      cyc(1);
      if (m_run) m_cnt = (m_cnt == 9999) ? 0 : m_cnt + 1;
   endtask

   task automatic press_ss();
      start_stop = 1'b1;
      cyc(1);
      start_stop = 1'b0;
      cyc(1);
      m_run = !m_run;
   endtask

   task automatic press_clr();
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      cyc(1);
      m_run = 1'b0;
      m_cnt = 0;
   endtask

   // Drive one slow_clk rise; expectation queued now, compared once the
   // registered display has caught up (idx edge + one output cycle).
   task automatic scan_step(input disp_t e);
      disp_t got;
      slow_clk = 1'b1;
      sb_q.push_back(e);
      cyc(1);
      slow_clk = 1'b0;
      cyc(1);
      got = sb_q.pop_front();
      chk(got.name, pk(an, seg, dp), pk(got.an, got.seg, got.dp));
   endtask

   task automatic scan_model(input string nm);
      m_idx = m_idx + 2'd1;
      scan_step(exp_disp(nm, m_cnt, m_idx));
   endtask

   task automatic check_display(input string nm);
      for (int k = 0; k < 4; k++) scan_model(nm);
   endtask

   initial begin
      disp_t e;
      tbl[0] = mk("scan_d0", 4'b1110, 7'h19, 1'b1);
      tbl[1] = mk("scan_d1", 4'b1101, 7'h30, 1'b1);
      tbl[2] = mk("scan_d2", 4'b1011, 7'h24, 1'b0);
      tbl[3] = mk("scan_d3", 4'b0111, 7'h79, 1'b1);
      tbl[4] = mk("scan_wrap", 4'b1110, 7'h19, 1'b1);

      reset = 1'b0; time_clk = 1'b0; slow_clk = 1'b0; start_stop = 1'b0; clear = 1'b0;

      // 1: reset held while time_clk toggles, start_stop high at release
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i % 4 == 0) time_clk = ~time_clk;
         if (i == 15) start_stop = 1'b1;
         if (i % 5 == 4) begin
            chk("rst_disp", pk(an, seg, dp), pk(4'hF, 7'h7F, 1'b1));
            chk1("rst_running", running, 1'b0);
         end
      end
      time_clk = 1'b1;
      reset = 1'b1;
      cyc(1);
      e = exp_disp("first_digit", 0, 2'd0);
      chk("first_digit", pk(an, seg, dp), pk(e.an, e.seg, e.dp));
      for (int i = 0; i < 12; i++) begin
         if (i % 2 == 0) time_clk = ~time_clk;
         cyc(1);
      end
      time_clk = 1'b0;
      chk1("idle_running", running, 1'b0);
      chk1("idle_overflow", overflow, 1'b0);
      start_stop = 1'b0;
      cyc(2);
      check_display("idle_zero");

      // 2: run 250 ticks, pause, 10 ignored ticks
      press_ss();
      chk1("run_running", running, 1'b1);
      repeat (250) tick();
      press_ss();
      chk1("pause_running", running, 1'b0);
      check_display("t2_250");
      repeat (10) tick();
      check_display("t2_held");

      // 3: 09.99 -> 10.00 in one tick, display one cycle later
      press_clr();
      press_ss();
      repeat (999) tick();
      check_display("t3_999");
      while (m_idx != 2'd3) scan_model("t3_align");
      time_clk = 1'b1;
      cyc(1);
      chk("t3_lag_old", pk(an, seg, dp), pk(4'b0111, 7'h7F, 1'b1));
      time_clk = 1'b0;
      cyc(1);
      chk("t3_lag_new", pk(an, seg, dp), pk(4'b0111, 7'h79, 1'b1));
      m_cnt = 1000;
      check_display("t3_1000");

      // 4: 99.99 boundary, both WRAP settings
      repeat (8999) tick();
      check_display("t4_9999");
      chk1("t4_pre_ovf", overflow, 1'b0);
      chk1("t4_pre_run_hold", running_h, 1'b1);
      tick();
      chk1("t4_wrap_ovf", overflow, 1'b1);
      chk1("t4_wrap_run", running, 1'b1);
      chk1("t4_hold_ovf", overflow_h, 1'b1);
      chk1("t4_hold_run", running_h, 1'b0);
      check_display("t4_wrap_zero");
      e = exp_disp("t4_hold_disp", 9999, m_idx);
      chk("t4_hold_disp", pk(an_h, seg_h, dp_h), pk(e.an, e.seg, e.dp));
      press_clr();
      chk1("t4_clr_ovf", overflow, 1'b0);
      chk1("t4_clr_ovf_hold", overflow_h, 1'b0);
      chk1("t4_clr_run", running, 1'b0);

      // 5: clear, start_stop and tick on the same cycle at 05.00
      press_ss();
      repeat (500) tick();
      check_display("t5_500");
      chk1("t5_pre_run", running, 1'b1);
      clear = 1'b1; start_stop = 1'b1; time_clk = 1'b1;
      cyc(1);
      m_cnt = 0; m_run = 1'b0;
      chk1("t5_coinc_run", running, 1'b0);
      clear = 1'b0; start_stop = 1'b0; time_clk = 1'b0;
      cyc(1);
      chk1("t5_after_run", running, 1'b0);
      check_display("t5_zero");

      // 6: scan order at 12.34
      press_ss();
      repeat (1234) tick();
      press_ss();
      while (m_idx != 2'd3) scan_model("t6_align");
      for (int k = 0; k < 5; k++) begin
         m_idx = m_idx + 2'd1;
         scan_step(tbl[k]);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
